// File: rtl/fp_align_ctrl.sv
// Exponent-alignment controller for the single-precision adder: orders two operands
// by magnitude and aligns the smaller significand through an external right shifter.
module fp_align_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sh_in,
    output logic [4:0]  sh_amt,
    input  logic [31:0] sh_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] big_mant,
    output logic [31:0] small_aligned,
    output logic [7:0]  exp_out,
    output logic        sign_big,
    output logic        sign_small,
    output logic        sticky
);

    typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [31:0] a_q, b_q;
    logic [7:0]  diff_q;
    logic [31:0] sh_in_q, big_mant_q, small_aligned_q;
    logic [4:0]  sh_amt_q;
    logic [7:0]  exp_out_q;
    logic        busy_q, done_q, sign_big_q, sign_small_q, sticky_q;

    logic [7:0]  ea, eb, diff_d, exp_out_d;
    logic [31:0] ma, mb, big_mant_d, small_mant_d;
    logic        a_big, sign_big_d, sign_small_d;

    function automatic logic [31:0] ext_mant(input logic [31:0] x);
        return {(x[30:23] != 8'd0), x[22:0], 8'd0};
    endfunction

    // Denormals sit at the same scale as exponent 1.
    function automatic logic [7:0] eff_exp(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    endfunction

    function automatic logic shifted_out(input logic [31:0] v, input logic [7:0] d);
        logic [31:0] mask;
        if (d >= 8'd32) return |v;
        mask = (32'd1 << d[4:0]) - 32'd1;
        return |(v & mask);
    endfunction

    always_comb begin
        ea    = eff_exp(a_q);
        eb    = eff_exp(b_q);
        ma    = ext_mant(a_q);
        mb    = ext_mant(b_q);
        // Significand compare (not raw fraction) so a normal beats a denormal at eff exp 1.
        a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
        if (a_big) begin
            big_mant_d   = ma;
            small_mant_d = mb;
            exp_out_d    = ea;
            diff_d       = ea - eb;
            sign_big_d   = a_q[31];
            sign_small_d = b_q[31];
        end else begin
            big_mant_d   = mb;
            small_mant_d = ma;
            exp_out_d    = eb;
            diff_d       = eb - ea;
            sign_big_d   = b_q[31];
            sign_small_d = a_q[31];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            diff_q          <= '0;
            sh_in_q         <= '0;
            sh_amt_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            big_mant_q      <= '0;
            small_aligned_q <= '0;
            exp_out_q       <= '0;
            sign_big_q      <= 1'b0;
            sign_small_q    <= 1'b0;
            sticky_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    big_mant_q   <= big_mant_d;
                    exp_out_q    <= exp_out_d;
                    sign_big_q   <= sign_big_d;
                    sign_small_q <= sign_small_d;
                    diff_q       <= diff_d;
                    sh_in_q      <= small_mant_d;
                    sh_amt_q     <= (diff_d < 8'd32) ? diff_d[4:0] : 5'd0;
                    state_q      <= SHIFT;
                end
                SHIFT: begin
                    small_aligned_q <= (diff_q < 8'd32) ? sh_out : 32'd0;
                    sticky_q        <= shifted_out(sh_in_q, diff_q);
                    done_q          <= 1'b1;
                    state_q         <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sh_in         = sh_in_q;
    assign sh_amt        = sh_amt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign big_mant      = big_mant_q;
    assign small_aligned = small_aligned_q;
    assign exp_out       = exp_out_q;
    assign sign_big      = sign_big_q;
    assign sign_small    = sign_small_q;
    assign sticky        = sticky_q;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed-vector bench for fp_align_ctrl with a behavioural right shifter.
module tb_fp_align_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] sh_in, sh_out, big_mant, small_aligned;
    logic [4:0]  sh_amt;
    logic [7:0]  exp_out;
    logic        busy, done, sign_big, sign_small, sticky;

    int checks = 0;
    int failures = 0;
    int lat;
    logic [4:0] amt_seen;

    always #5 clk = ~clk;

    assign sh_out = sh_in >> sh_amt;

    fp_align_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .sh_in(sh_in), .sh_amt(sh_amt), .sh_out(sh_out),
        .busy(busy), .done(done), .big_mant(big_mant),
        .small_aligned(small_aligned), .exp_out(exp_out),
        .sign_big(sign_big), .sign_small(sign_small), .sticky(sticky)
    );

    // Start one operation at a falling edge and watch until done (bounded).
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        lat = -1;
        amt_seen = 5'h1f;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 2) amt_seen = sh_amt;
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({sh_in, sh_amt, busy, done, big_mant, small_aligned, exp_out,
             sign_big, sign_small, sticky} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b big=%h small=%h exp=%h", busy, done, big_mant, small_aligned, exp_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        run_op(32'h40400000, 32'h3F800000);
        checks++;
        if ({big_mant, small_aligned, exp_out, sticky, sign_big, sign_small} !==
            {32'hC0000000, 32'h40000000, 8'h80, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic: big=%h small=%h exp=%h st=%b sb=%b ss=%b want c0000000 40000000 80 0 0 0",
                     big_mant, small_aligned, exp_out, sticky, sign_big, sign_small);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_in_done: got %b want 1", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (big_mant !== 32'hC0000000 || small_aligned !== 32'h40000000) begin
            failures++;
            $display("FAIL basic_hold: big=%h small=%h", big_mant, small_aligned);
        end
    endtask

    task automatic test_swap;
        run_op(32'hBF800000, 32'h40400000);
        checks++;
        if ({big_mant, small_aligned, exp_out, sign_big, sign_small} !==
            {32'hC0000000, 32'h40000000, 8'h80, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL swap: big=%h small=%h exp=%h sb=%b ss=%b want c0000000 40000000 80 0 1",
                     big_mant, small_aligned, exp_out, sign_big, sign_small);
        end
    endtask

    task automatic test_sticky;
        run_op(32'h44000000, 32'h3F800001);
        checks++;
        if (amt_seen !== 5'd9) begin
            failures++;
            $display("FAIL sticky_amt: got %0d want 9", amt_seen);
        end
        checks++;
        if ({big_mant, small_aligned, exp_out, sticky} !== {32'h80000000, 32'h00400000, 8'h88, 1'b1}) begin
            failures++;
            $display("FAIL sticky: big=%h small=%h exp=%h st=%b want 80000000 00400000 88 1",
                     big_mant, small_aligned, exp_out, sticky);
        end
    endtask

    task automatic test_out_of_range;
        run_op(32'h4F800000, 32'h3F800000);
        checks++;
        if (amt_seen !== 5'd0) begin
            failures++;
            $display("FAIL oor_amt: got %0d want 0", amt_seen);
        end
        checks++;
        if ({small_aligned, sticky, exp_out} !== {32'h0, 1'b1, 8'h9F}) begin
            failures++;
            $display("FAIL oor: small=%h st=%b exp=%h want 00000000 1 9f", small_aligned, sticky, exp_out);
        end
    endtask

    task automatic test_denormal_tie;
        run_op(32'h00000001, 32'h00800000);
        checks++;
        if (amt_seen !== 5'd0) begin
            failures++;
            $display("FAIL denorm_amt: got %0d want 0", amt_seen);
        end
        checks++;
        if ({big_mant, small_aligned, exp_out, sticky} !== {32'h80000000, 32'h00000100, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL denorm: big=%h small=%h exp=%h st=%b want 80000000 00000100 01 0",
                     big_mant, small_aligned, exp_out, sticky);
        end
        run_op(32'h3F800000, 32'hBF800000);
        checks++;
        if ({big_mant, small_aligned, exp_out, sticky, sign_big, sign_small} !==
            {32'h80000000, 32'h80000000, 8'h7F, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL tie: big=%h small=%h exp=%h st=%b sb=%b ss=%b want 80000000 80000000 7f 0 0 1",
                     big_mant, small_aligned, exp_out, sticky, sign_big, sign_small);
        end
    endtask

    task automatic test_start_ignored;
        @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; start = 1'b1;
        @(negedge clk);
        a = 32'h4F800000; b = 32'hBF800001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_done: got %b want 1", done);
        end
        checks++;
        if ({big_mant, small_aligned, exp_out, sticky, sign_small} !==
            {32'hC0000000, 32'h40000000, 8'h80, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ignore_result: big=%h small=%h exp=%h st=%b ss=%b want c0000000 40000000 80 0 0",
                     big_mant, small_aligned, exp_out, sticky, sign_small);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_not_queued: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_op;
        int seen_done;
        @(negedge clk);
        a = 32'h44000000; b = 32'h3F800001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sh_in, sh_amt, busy, done, big_mant, small_aligned, exp_out,
             sign_big, sign_small, sticky} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: sh_in=%h amt=%0d busy=%b big=%h exp=%h", sh_in, sh_amt, busy, big_mant, exp_out);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL midreset_no_done: activity cycles=%0d want 0", seen_done);
        end
        run_op(32'h4F800000, 32'h3F800000);
        checks++;
        if ({small_aligned, sticky, exp_out} !== {32'h0, 1'b1, 8'h9F}) begin
            failures++;
            $display("FAIL midreset_next: small=%h st=%b exp=%h want 00000000 1 9f", small_aligned, sticky, exp_out);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        int first;
        @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; start = 1'b1;
        pulses = 0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 3 || first !== 3) begin
            failures++;
            $display("FAIL back_to_back: pulses=%0d first=%0d want 3 3", pulses, first);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_sticky();
        test_out_of_range();
        test_denormal_tie();
        test_start_ignored();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
